// File: rtl/vp_pkg.sv
// Shared constants, encodings and the write-back bundle type for the vector memory stage.
// Lane geometry is fixed here; the stride option (MEM_STRIDE_EN) lives in mem_stage.
package vp_pkg;

   localparam int LANES  = 8;
   localparam int LANE_W = 24;
   localparam int ADDR_W = 21;
   localparam int VEC_W  = LANES * LANE_W;
   localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      MEM_NONE   = 2'b00,
      MEM_VLOAD  = 2'b01,
      MEM_VSTORE = 2'b10
   } mem_op_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STORE,
      DONE
   } state_e;

   typedef struct packed {
      logic [3:0]        dest;
      logic              destType;
      logic [VEC_W-1:0]  memData;
      logic [ADDR_W-1:0] regE;
      logic [VEC_W-1:0]  regV;
      logic [1:0]        wb;
   } wb_bundle_t;

endpackage

// File: rtl/mem_lane_seq.sv
// Beat sequencer for vector memory ops: beat counter, running lane address,
// store-lane selection and load-lane assembly.
module mem_lane_seq
   import vp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] step,
   input  logic              beat_done,
   input  logic              capture,
   input  logic [LANE_W-1:0] rdata,
   input  logic [VEC_W-1:0]  store_vec,
   output logic [ADDR_W-1:0] addr,
   output logic [LANE_W-1:0] lane_data,
   output logic              last_beat,
   output logic [VEC_W-1:0]  lanes
);

   logic [BEAT_W-1:0] beat;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] step_q;

   assign last_beat = (beat == BEAT_W'(LANES - 1));
   assign addr      = addr_q;
   assign lane_data = store_vec[beat*LANE_W +: LANE_W];

   // The address accumulates the step on every completed beat, wrapping at ADDR_W bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat   <= '0;
         addr_q <= '0;
         step_q <= '0;
      end else if (start) begin
         beat   <= '0;
         addr_q <= base;
         step_q <= step;
      end else if (beat_done) begin
         beat   <= last_beat ? '0 : beat + BEAT_W'(1);
         addr_q <= addr_q + step_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes <= '0;
      end else if (capture) begin
         lanes[beat*LANE_W +: LANE_W] <= rdata;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Vector memory stage: ALU pass-through or lane-serial load/store, registered WB bundle.
// Define MEM_STRIDE_EN to use ex_stride as the lane address step (default step is 1).
module mem_stage
   import vp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [3:0]        ex_dest,
   input  logic              ex_destType,
   input  logic [ADDR_W-1:0] ex_regE,
   input  logic [VEC_W-1:0]  ex_regV,
   input  logic [1:0]        ex_wb,
   input  logic [1:0]        ex_mem,
   input  logic [ADDR_W-1:0] ex_stride,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LANE_W-1:0] mem_wdata,
   input  logic [LANE_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic              wb_valid,
   output logic [3:0]        dest,
   output logic              destType,
   output logic [VEC_W-1:0]  memData,
   output logic [ADDR_W-1:0] regE,
   output logic [VEC_W-1:0]  regV,
   output logic [1:0]        wb
);

   state_e            state;
   state_e            state_nxt;
   logic              op_load;
   logic              op_store;
   logic              accept;
   logic              busy;
   logic              beat_done;
   logic              last_beat;
   logic              is_load;
   logic              stall_c;
   logic              req_c;
   logic              we_c;
   logic              capture_en;
   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] seq_addr;
   logic [LANE_W-1:0] lane_data;
   logic [VEC_W-1:0]  lanes;
   wb_bundle_t        bundle;
   wb_bundle_t        bundle_nxt;
   logic              wb_valid_q;

`ifdef MEM_STRIDE_EN
   assign step = ex_stride;
`else
   logic stride_unused;
   assign stride_unused = ^ex_stride;
   assign step = ADDR_W'(1);
`endif

   assign op_load   = ex_valid && (ex_mem == MEM_VLOAD);
   assign op_store  = ex_valid && (ex_mem == MEM_VSTORE);
   assign accept    = (state == IDLE) && (op_load || op_store);
   assign busy      = (state == LOAD) || (state == STORE);
   assign beat_done = busy && mem_ack;

   mem_lane_seq u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (accept),
      .base      (ex_regE),
      .step      (step),
      .beat_done (beat_done),
      .capture   (beat_done && (state == LOAD)),
      .rdata     (mem_rdata),
      .store_vec (ex_regV),
      .addr      (seq_addr),
      .lane_data (lane_data),
      .last_beat (last_beat),
      .lanes     (lanes)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stall_c   = 1'b0;
      req_c     = 1'b0;
      we_c      = 1'b0;
      case (state)
         IDLE: begin
            if (op_load) begin
               state_nxt = LOAD;
               stall_c   = 1'b1;
            end else if (op_store) begin
               state_nxt = STORE;
               stall_c   = 1'b1;
            end
         end
         LOAD: begin
            stall_c = 1'b1;
            req_c   = 1'b1;
            if (mem_ack && last_beat) state_nxt = DONE;
         end
         STORE: begin
            stall_c = 1'b1;
            req_c   = 1'b1;
            we_c    = 1'b1;
            if (mem_ack && last_beat) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // stall also depends on live ex_* inputs, so gate it with reset to keep it low during reset.
   assign stall     = stall_c & rst_n;
   assign mem_req   = req_c;
   assign mem_we    = we_c;
   assign mem_addr  = req_c ? seq_addr : '0;
   assign mem_wdata = we_c ? lane_data : '0;

   assign capture_en = ((state == IDLE) && ex_valid && !accept) || (state == DONE);

   always_comb begin
      bundle_nxt.dest     = ex_dest;
      bundle_nxt.destType = ex_destType;
      bundle_nxt.memData  = ((state == DONE) && is_load) ? lanes : bundle.memData;
      bundle_nxt.regE     = ex_regE;
      bundle_nxt.regV     = ex_regV;
      bundle_nxt.wb       = ex_wb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         bundle     <= '0;
         is_load    <= 1'b0;
      end else begin
         wb_valid_q <= capture_en;
         if (capture_en) bundle <= bundle_nxt;
         if (accept) is_load <= op_load;
      end
   end

   assign wb_valid = wb_valid_q;
   assign dest     = bundle.dest;
   assign destType = bundle.destType;
   assign memData  = bundle.memData;
   assign regE     = bundle.regE;
   assign regV     = bundle.regV;
   assign wb       = wb_valid_q ? bundle.wb : 2'b00;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard queues for memory beats and WB bundles.
// Expected beat addresses follow MEM_STRIDE_EN when the bench is built with it.
module tb_mem_stage;
   import vp_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              ex_valid;
   logic [3:0]        ex_dest;
   logic              ex_destType;
   logic [ADDR_W-1:0] ex_regE;
   logic [VEC_W-1:0]  ex_regV;
   logic [1:0]        ex_wb;
   logic [1:0]        ex_mem;
   logic [ADDR_W-1:0] ex_stride;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LANE_W-1:0] mem_wdata;
   logic [LANE_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              stall;
   logic              wb_valid;
   logic [3:0]        dest;
   logic              destType;
   logic [VEC_W-1:0]  memData;
   logic [ADDR_W-1:0] regE;
   logic [VEC_W-1:0]  regV;
   logic [1:0]        wb;

   int n_vec = 0;
   int n_err = 0;

   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [LANE_W-1:0] exp_wdata_q[$];
   wb_bundle_t        exp_wb_q[$];
   logic [VEC_W-1:0]  cur_memdata;

   mem_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_valid    (ex_valid),
      .ex_dest     (ex_dest),
      .ex_destType (ex_destType),
      .ex_regE     (ex_regE),
      .ex_regV     (ex_regV),
      .ex_wb       (ex_wb),
      .ex_mem      (ex_mem),
      .ex_stride   (ex_stride),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .dest        (dest),
      .destType    (destType),
      .memData     (memData),
      .regE        (regE),
      .regV        (regV),
      .wb          (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: memory[100+i] = 24'h10+i, extended linearly over the address space.
   function automatic logic [LANE_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
      return {3'b000, a} - 24'd84;
   endfunction

   function automatic wb_bundle_t observed();
      wb_bundle_t g;
      g.dest     = dest;
      g.destType = destType;
      g.memData  = memData;
      g.regE     = regE;
      g.regV     = regV;
      g.wb       = wb;
      return g;
   endfunction

   task automatic test_reset();
      rst_n       = 1'b0;
      ex_valid    = 1'b1;
      ex_mem      = 2'b01;
      ex_dest     = 4'hF;
      ex_destType = 1'b1;
      ex_regE     = 21'h12345;
      ex_regV     = {VEC_W{1'b1}};
      ex_wb       = 2'b11;
      ex_stride   = 21'd3;
      mem_ack     = 1'b1;
      mem_rdata   = 24'hFFFFFF;
      cur_memdata = '0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, stall, wb_valid} !== '0) begin
         n_err++;
         $display("FAIL reset_ctrl: req=%b we=%b addr=%h wdata=%h stall=%b wb_valid=%b, all required 0",
                  mem_req, mem_we, mem_addr, mem_wdata, stall, wb_valid);
      end
      n_vec++;
      if (observed() !== '0) begin
         n_err++;
         $display("FAIL reset_bundle: dest=%h destType=%b regE=%h wb=%b, all required 0",
                  dest, destType, regE, wb);
      end
      @(negedge clk);
      ex_valid = 1'b0;
      ex_mem   = 2'b00;
      mem_ack  = 1'b0;
      rst_n    = 1'b1;
   endtask

   task automatic test_passthru(input logic [1:0] op, input logic [ADDR_W-1:0] e_val,
                                input logic [3:0] d, input logic [1:0] w, input string name);
      wb_bundle_t e;
      @(negedge clk);
      ex_valid    = 1'b1;
      ex_mem      = op;
      ex_regE     = e_val;
      ex_regV     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ex_dest     = d;
      ex_destType = 1'b0;
      ex_wb       = w;
      e.dest = d; e.destType = 1'b0; e.memData = cur_memdata;
      e.regE = e_val; e.regV = ex_regV; e.wb = w;
      exp_wb_q.push_back(e);
      #1;
      n_vec++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL %s_stall: stall=%b mem_req=%b, required 0 0", name, stall, mem_req);
      end
      @(negedge clk);
      ex_valid = 1'b0;
      #1;
      e = exp_wb_q.pop_front();
      n_vec++;
      if (wb_valid !== 1'b1 || observed() !== e) begin
         n_err++;
         $display("FAIL %s_out: wb_valid=%b dest=%h regE=%h wb=%b, required 1 %h %h %b",
                  name, wb_valid, dest, regE, wb, e.dest, e.regE, e.wb);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (wb_valid !== 1'b0 || wb !== 2'b00) begin
         n_err++;
         $display("FAIL %s_bubble: wb_valid=%b wb=%b, required 0 00", name, wb_valid, wb);
      end
   endtask

   task automatic test_back_to_back();
      wb_bundle_t e;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            #1;
            e = exp_wb_q.pop_front();
            n_vec++;
            if (wb_valid !== 1'b1 || observed() !== e) begin
               n_err++;
               $display("FAIL b2b_%0d: wb_valid=%b dest=%h regE=%h wb=%b, required 1 %h %h %b",
                        k - 1, wb_valid, dest, regE, wb, e.dest, e.regE, e.wb);
            end
         end
         if (k < 3) begin
            ex_valid    = 1'b1;
            ex_mem      = (k == 1) ? 2'b11 : 2'b00;
            ex_regE     = 21'(32'h1000 * (k + 1) + 7);
            ex_regV     = {6{$urandom}};
            ex_dest     = 4'(k + 8);
            ex_destType = k[0];
            ex_wb       = 2'(k + 1);
            e.dest = ex_dest; e.destType = ex_destType; e.memData = cur_memdata;
            e.regE = ex_regE; e.regV = ex_regV; e.wb = ex_wb;
            exp_wb_q.push_back(e);
         end else begin
            ex_valid = 1'b0;
         end
      end
   endtask

   task automatic run_mem_op(input logic [1:0] op, input logic [ADDR_W-1:0] base,
                             input logic [ADDR_W-1:0] stride, input logic [VEC_W-1:0] vec,
                             input logic [1:0] w, input int wait_n, input string name);
      logic [ADDR_W-1:0] stp;
      logic [ADDR_W-1:0] a;
      logic [VEC_W-1:0]  ld;
      wb_bundle_t        e;
      int                stall_cnt;
      int                beats;
      int                waitc;
      bit                done;
`ifdef MEM_STRIDE_EN
      stp = stride;
`else
      stp = 21'd1;
`endif
      ld = cur_memdata;
      for (int i = 0; i < LANES; i++) begin
         a = base + stp * 21'(i);
         exp_addr_q.push_back(a);
         exp_wdata_q.push_back(vec[i*LANE_W +: LANE_W]);
         if (op == 2'b01) ld[i*LANE_W +: LANE_W] = mem_val(a);
      end
      e.dest = 4'd5; e.destType = 1'b1; e.memData = ld;
      e.regE = base; e.regV = vec; e.wb = w;
      exp_wb_q.push_back(e);
      @(negedge clk);
      ex_valid    = 1'b1;
      ex_mem      = op;
      ex_regE     = base;
      ex_regV     = vec;
      ex_stride   = stride;
      ex_dest     = 4'd5;
      ex_destType = 1'b1;
      ex_wb       = w;
      stall_cnt = 0;
      beats     = 0;
      waitc     = 0;
      done      = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         #1;
         mem_ack = 1'b0;
         if (stall) stall_cnt++;
         else done = 1'b1;
         if (mem_req) begin
            n_vec++;
            if (exp_addr_q.size() == 0) begin
               n_err++;
               $display("FAIL %s_extra_beat: mem_req=1 addr=%h, required no further beat", name, mem_addr);
            end else begin
               if (mem_addr !== exp_addr_q[0] || mem_we !== (op == 2'b10)) begin
                  n_err++;
                  $display("FAIL %s_beat%0d: addr=%h we=%b, required %h %b",
                           name, beats, mem_addr, mem_we, exp_addr_q[0], (op == 2'b10));
               end
               if (op == 2'b10) begin
                  n_vec++;
                  if (mem_wdata !== exp_wdata_q[0]) begin
                     n_err++;
                     $display("FAIL %s_wdata%0d: wdata=%h, required %h",
                              name, beats, mem_wdata, exp_wdata_q[0]);
                  end
               end
               if (waitc == wait_n) begin
                  mem_ack   = 1'b1;
                  mem_rdata = mem_val(exp_addr_q[0]);
                  void'(exp_addr_q.pop_front());
                  void'(exp_wdata_q.pop_front());
                  beats++;
                  waitc = 0;
               end else begin
                  waitc++;
               end
            end
         end
         @(negedge clk);
      end
      ex_valid = 1'b0;
      mem_ack  = 1'b0;
      #1;
      n_vec++;
      if (!done || beats != LANES || stall_cnt != 1 + LANES * (wait_n + 1)) begin
         n_err++;
         $display("FAIL %s_timing: done=%0d beats=%0d stall_cycles=%0d, required 1 %0d %0d",
                  name, done, beats, stall_cnt, LANES, 1 + LANES * (wait_n + 1));
      end
      e = exp_wb_q.pop_front();
      n_vec++;
      if (wb_valid !== 1'b1 || observed() !== e) begin
         n_err++;
         $display("FAIL %s_wb: wb_valid=%b memData=%h regE=%h wb=%b, required 1 %h %h %b",
                  name, wb_valid, memData, regE, wb, e.memData, e.regE, e.wb);
      end
      cur_memdata = e.memData;
      @(negedge clk);
      #1;
      n_vec++;
      if (wb_valid !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL %s_after: wb_valid=%b stall=%b mem_req=%b, required 0 0 0",
                  name, wb_valid, stall, mem_req);
      end
   endtask

   task automatic test_ack_idle();
      @(negedge clk);
      ex_valid = 1'b0;
      mem_ack  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         n_vec++;
         if (mem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ack_idle_%0d: req=%b stall=%b wb_valid=%b, required 0 0 0",
                     k, mem_req, stall, wb_valid);
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      int beats;
      beats = 0;
      @(negedge clk);
      ex_valid    = 1'b1;
      ex_mem      = 2'b01;
      ex_regE     = 21'd200;
      ex_stride   = 21'd1;
      ex_dest     = 4'd2;
      ex_destType = 1'b1;
      ex_wb       = 2'b10;
      for (int c = 0; c < 40 && beats < 4; c++) begin
         #1;
         mem_ack = 1'b0;
         if (mem_req) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_val(mem_addr);
            beats++;
         end
         @(negedge clk);
      end
      #1;
      mem_ack = 1'b0;
      n_vec++;
      if (beats != 4 || mem_req !== 1'b1 || stall !== 1'b1) begin
         n_err++;
         $display("FAIL midload_setup: beats=%0d req=%b stall=%b, required 4 1 1", beats, mem_req, stall);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midload_reset: req=%b stall=%b wb_valid=%b, required 0 0 0",
                  mem_req, stall, wb_valid);
      end
      exp_addr_q.delete();
      exp_wdata_q.delete();
      exp_wb_q.delete();
      cur_memdata = '0;
      @(negedge clk);
      ex_valid = 1'b0;
      ex_mem   = 2'b00;
      rst_n    = 1'b1;
   endtask

   initial begin
      logic [VEC_W-1:0] svec;
      for (int i = 0; i < LANES; i++) svec[i*LANE_W +: LANE_W] = 24'hA00000 + 24'(i);

      test_reset();
      test_passthru(2'b00, 21'h1ABCD, 4'd3, 2'b01, "passthru");
      test_passthru(2'b11, 21'h0F0F0, 4'd7, 2'b10, "reserved_op");
      test_back_to_back();
      run_mem_op(2'b01, 21'd100, 21'd0, {6{32'h5555AAAA}}, 2'b10, 0, "load");
      run_mem_op(2'b10, 21'h00400, 21'd0, svec, 2'b01, 2, "store");
      run_mem_op(2'b01, 21'h1FFFFE, 21'd0, '0, 2'b10, 1, "wrap");
      run_mem_op(2'b01, 21'd0, 21'd4, '0, 2'b10, 0, "stride");
      test_ack_idle();
      test_reset_mid_load();
      test_passthru(2'b00, 21'h1ABCD, 4'd3, 2'b01, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Vector-processor memory stage, directly upstream of the write-back stage.
- Takes EX results and performs vector load/store over a narrow lane-wide data-memory port, one lane per beat.
- Stalls the front of the pipeline while beats are in flight.
- Registers the write-back bundle (dest, destType, memData, regE, regV, wb) for the write-back stage.

Parameters:
- LANES, 8, vector lanes per vector register.
- LANE_W, 24, bits per lane; LANES*LANE_W = 192.
- ADDR_W, 21, data-memory word-address width; equals scalar width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX presents an instruction this cycle.
- ex_dest  in  4  destination register index.
- ex_destType  in  1  0 = scalar destination, 1 = vector destination.
- ex_regE  in  21  scalar ALU result; also the base address for memory ops.
- ex_regV  in  192  vector ALU result; also store data.
- ex_wb  in  2  write-back control; wb[1]=1 selects memory data at WB.
- ex_mem  in  2  00 none, 01 vector load, 10 vector store, 11 reserved (treated as none).
- ex_stride  in  21  lane address stride; used only with MEM_STRIDE_EN.
- mem_req  out  1  beat request to data memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  21  beat word address.
- mem_wdata  out  24  beat write data.
- mem_rdata  in  24  beat read data; valid with mem_ack.
- mem_ack  in  1  beat completes this cycle.
- stall  out  1  hold EX/ID/IF; the current ex_* inputs must stay stable.
- wb_valid  out  1  the WB bundle is valid this cycle.
- dest  out  4  to WB.
- destType  out  1  to WB.
- memData  out  192  assembled load data, lane i in bits [24i+23:24i].
- regE  out  21  to WB.
- regV  out  192  to WB.
- wb  out  2  to WB; forced 00 when wb_valid=0 so WB writes nothing.

Behaviour:
- Reset, asynchronous and active-low: all outputs go to 0; FSM state IDLE; beat counter 0; memData assembly buffer 0.
- FSM states:
  - IDLE:
    - ex_valid & ex_mem in {00,11}: register the bundle next edge with wb_valid=1 and memData unchanged. Latency 1 cycle, stall=0.
    - ex_valid & ex_mem=01: go to LOAD.
    - ex_valid & ex_mem=10: go to STORE.
    - In both load and store cases: stall=1 combinationally in that same cycle; beat=0; base latched from ex_regE; wb_valid=0 next edge.
    - !ex_valid: wb_valid=0 next edge, all other bundle registers hold.
  - LOAD:
    - mem_req=1, mem_we=0, mem_addr = base + beat*STEP, truncated to 21 bits (wrap, no error).
    - On mem_ack: lane[beat] <= mem_rdata, then beat++.
    - Ack with beat=LANES-1: go to DONE.
    - No ack: hold address and request (request stays asserted until ack).
  - STORE:
    - As LOAD, but mem_we=1 and mem_wdata = ex_regV lane[beat].
    - Last ack goes to DONE.
  - DONE:
    - Register the bundle with wb_valid=1; memData = assembled lanes for a load, unchanged for a store.
    - wb is passed through as-is; a store with wb!=00 is a software error and is not masked.
    - stall=0 in DONE so EX advances on that same edge; return to IDLE.
- STEP = 1 without MEM_STRIDE_EN.
- stall=1 in LOAD and STORE, and in IDLE when a memory op is being accepted; stall=0 otherwise.
- A memory op costs 1 + (LANES beats, plus any ack wait cycles) + 1 DONE cycle; minimum 10 cycles for LANES=8.
- mem_ack outside LOAD/STORE is ignored.
- mem_ack in the same cycle the FSM enters LOAD/STORE is impossible, because mem_req is not yet asserted.
- Reset mid-operation: the FSM aborts to IDLE immediately, partial lanes are discarded, and mem_req drops asynchronously.

Optional Feature:
- Macro MEM_STRIDE_EN.
- Defined: ex_stride is latched at acceptance and STEP = latched stride (21-bit wrap); a stride of 0 is legal and repeats the base address.
- Undefined: the ex_stride port still exists but is ignored, and STEP = 1.

Decomposition:
- Shared package vp_pkg:
  - LANES, LANE_W, ADDR_W.
  - Mem-op encoding enum (MEM_NONE, MEM_VLOAD, MEM_VSTORE).
  - FSM state enum (IDLE, LOAD, STORE, DONE).
  - Packed wb_bundle_t struct (dest, destType, memData, regE, regV, wb).
- One natural sub-module: mem_lane_seq. It owns the beat counter, the address generator and lane selection/assembly, and reports last_beat. The FSM and the output register stay in mem_stage.

Test Plan:
- ALU pass-through: ex_valid=1, ex_mem=00, ex_regE=21'h1ABCD, ex_dest=3, ex_wb=01 -> next cycle wb_valid=1, regE=21'h1ABCD, dest=3, wb=01, stall stays 0.
- Vector load, zero-wait memory where memory[100+i] = 24'h000010+i: ex_mem=01, ex_regE=100 -> mem_addr 100..107 on consecutive cycles. DONE cycle gives memData lane i = 24'h10+i, wb_valid=1 once, stall high for exactly 9 cycles.
- Vector store with ack delayed 2 cycles per beat, ex_regV lane i = 24'hA00000+i -> mem_addr/mem_wdata held stable during the waits, 8 writes observed, DONE at cycle 1+24+1.
- Address wrap: ex_regE = 21'h1FFFFE, load -> beat addresses 1FFFFE, 1FFFFF, 0, 1, ..., 5.
- Reset mid-load: assert rst_n=0 after beat 3 -> mem_req, stall and wb_valid go 0 immediately. After release, a pass-through op behaves as in the first scenario.
- With MEM_STRIDE_EN, ex_stride=4, base 0 -> addresses 0, 4, 8, ..., 28. Without the macro, the same stimulus -> addresses 0..7.
